mem_word_access: RTL and testbench

//  Memory-side consumer of the address register file's address outputs.

---
 rtl/mem_word_access_pkg.sv | 28 ++
 rtl/mem_wait_timer.sv | 30 +++
 rtl/mem_word_access.sv | 176 +++++++++++++++++
 tb/tb_mem_word_access.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_word_access_pkg.sv
// Shared types and constants for the 16-bit word access engine over a byte-wide memory.
// Word and byte widths, FSM state encoding, default timeout and the byte lane helpers.
package mem_word_access_pkg;

    localparam int WORD_W          = 16;
    localparam int BYTE_W          = 8;
    localparam int TIMER_W         = 8;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE0 = 2'd1,
        ST_BYTE1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Upper lane lives at base+1; the increment wraps naturally at 16 bits.
    function automatic logic [WORD_W-1:0] byte_addr(input logic [WORD_W-1:0] base,
                                                     input logic              upper);
        return upper ? base + WORD_W'(1) : base;
    endfunction

    function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                   input logic              upper);
        return upper ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state down-counter: reloaded on every byte-state entry, counts MemReady-low cycles.
// expired flags that the current low cycle is the last one allowed before abort.
module mem_wait_timer
    import mem_word_access_pkg::*;
#(
    parameter int W     = TIMER_W,
    parameter int START = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic dec,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= W'(START);
        end else if (clear) begin
            count <= W'(START);
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count <= W'(1));

endmodule

// File: rtl/mem_word_access.sv
// Splits a 16-bit word read/write into two little-endian byte accesses on an 8-bit memory.
// Handshake with the control unit is Start/Busy/Done; Error flags a wait-state timeout abort.
//
// Handshake: start is sampled only in IDLE; busy spans the byte states and the done cycle;
// done is a single-cycle pulse with error valid alongside it. On the memory side a byte
// access completes on any cycle where mem_ready is high while the strobe is asserted.
module mem_word_access
    import mem_word_access_pkg::*;
#(
    parameter int TIMEOUT  = DEFAULT_TIMEOUT,
    parameter bit HI_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              write,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output state_t            dbg_state
);

    state_t state_q;
    state_t state_d;

    logic              op_write_q;
    logic [WORD_W-1:0] op_addr_q;
    logic [WORD_W-1:0] op_wdata_q;
    logic [BYTE_W-1:0] first_byte_q;

    logic accept;
    logic in_byte;
    logic in_byte_d;
    logic timer_clear;
    logic timer_dec;
    logic timer_expired;
    logic timeout_hit;

    logic              eff_write;
    logic [WORD_W-1:0] eff_addr;
    logic [WORD_W-1:0] eff_wdata;
    logic              upper_d;

    logic              busy_d;
    logic              done_d;
    logic              error_d;
    logic              mem_rd_d;
    logic              mem_wr_d;
    logic [WORD_W-1:0] mem_addr_d;
    logic [BYTE_W-1:0] mem_wdata_d;

    assign accept      = (state_q == ST_IDLE) && start;
    assign in_byte     = (state_q == ST_BYTE0) || (state_q == ST_BYTE1);
    assign timeout_hit = in_byte && !mem_ready && timer_expired;
    assign dbg_state   = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_BYTE0;
            end
            ST_BYTE0: begin
                if (mem_ready)          state_d = ST_BYTE1;
                else if (timer_expired) state_d = ST_DONE;
            end
            ST_BYTE1: begin
                if (mem_ready || timer_expired) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs. On the accepting edge the
    // request fields are taken straight from the ports so BYTE0 strobes appear at once.
    always_comb begin
        eff_write   = accept ? write   : op_write_q;
        eff_addr    = accept ? address : op_addr_q;
        eff_wdata   = accept ? wdata   : op_wdata_q;
        in_byte_d   = (state_d == ST_BYTE0) || (state_d == ST_BYTE1);
        upper_d     = (state_d == ST_BYTE1) ^ HI_FIRST;

        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        error_d     = done_d && timeout_hit;
        mem_rd_d    = in_byte_d && !eff_write;
        mem_wr_d    = in_byte_d && eff_write;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if (in_byte_d) begin
            mem_addr_d  = byte_addr(eff_addr, upper_d);
            mem_wdata_d = byte_sel(eff_wdata, upper_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
            mem_rd    <= mem_rd_d;
            mem_wr    <= mem_wr_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Request capture and read assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_write_q   <= 1'b0;
            op_addr_q    <= '0;
            op_wdata_q   <= '0;
            first_byte_q <= '0;
            rdata        <= '0;
        end else begin
            if (accept) begin
                op_write_q <= write;
                op_addr_q  <= address;
                op_wdata_q <= wdata;
            end
            if ((state_q == ST_BYTE0) && mem_ready) begin
                first_byte_q <= mem_rdata;
            end
            // rdata only moves on a read whose second byte completed; aborts leave it alone.
            if ((state_q == ST_BYTE1) && mem_ready && !op_write_q) begin
                rdata <= HI_FIRST ? {first_byte_q, mem_rdata} : {mem_rdata, first_byte_q};
            end
        end
    end

    assign timer_clear = in_byte_d && (state_d != state_q);
    assign timer_dec   = in_byte && !mem_ready;

    mem_wait_timer #(
        .W     (TIMER_W),
        .START (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .dec     (timer_dec),
        .expired (timer_expired)
    );

endmodule

// File: tb/tb_mem_word_access.sv
// Bench for mem_word_access: byte memory responder with programmable wait states,
// directed scenarios plus randomized word operations checked against a word-level model.
module tb_mem_word_access;
    import mem_word_access_pkg::*;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        write = 1'b0;
    logic [15:0] address = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic        busy, done, error, mem_rd, mem_wr;
    logic [15:0] rdata, mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ready = 1'b0;
    state_t      dbg_state;

    int tests = 0;
    int fails = 0;

    logic [7:0]  tb_mem  [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] exp_q[$];
    logic [15:0] ref_rdata = 16'h0;

    int waits_cfg = 0;
    int stuck_mode = 0;
    int acc_n = 0;
    int cnt = 0;
    bit act_prev = 0;
    bit rdy_prev = 0;
    bit cur_wr = 0;

    // Clock / reset
    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr];

    mem_word_access #(.TIMEOUT(T), .HI_FIRST(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .write     (write),
        .address   (address),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory responder: waits_cfg low cycles per byte, optional stuck byte, noise when idle.
    always @(posedge clk) begin
        #1;
        if (mem_rd || mem_wr) begin
            if (act_prev && rdy_prev) acc_n++;
            if (!act_prev || rdy_prev) cnt = 0;
            else cnt++;
            mem_ready = !((stuck_mode == 1) || (stuck_mode == 2 && acc_n >= 1))
                        && (cnt >= waits_cfg);
            act_prev = 1;
            rdy_prev = mem_ready;
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            act_prev = 0;
            rdy_prev = 0;
        end
    end

    // Scoreboard of completed byte accesses; also commits write bytes to memory.
    always @(negedge clk) begin
        if (rst_n && (mem_rd || mem_wr) && mem_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_access", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("byte_addr", {16'h0, mem_addr}, {16'h0, exp_q.pop_front()});
                chk("byte_strobe", {30'h0, mem_rd, mem_wr}, cur_wr ? 32'h1 : 32'h2);
            end
            if (mem_wr) tb_mem[mem_addr] = mem_wdata;
        end
    end

    task automatic launch(input bit wr, input logic [15:0] a, input logic [15:0] d,
                          input int w, input int sm, input bit b2b);
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        waits_cfg  = w;
        stuck_mode = sm;
        acc_n      = 0;
        cur_wr     = wr;
        if (sm != 1) exp_q.push_back(a);
        if (sm == 0) exp_q.push_back(a + 16'd1);
        start   = 1'b1;
        write   = wr;
        address = a;
        wdata   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input bit wr, input logic [15:0] a,
                          input logic [15:0] d, input int w, input int sm,
                          input bit b2b, input bit poke);
        int          lat;
        int          got;
        bit          busy_ok;
        bit          strobe_ok;
        logic [15:0] a1;
        a1  = a + 16'd1;
        lat = (sm == 0) ? 2 + 2 * w : (sm == 1) ? T : w + 1 + T;
        launch(wr, a, d, w, sm, b2b);
        if (poke) begin
            address = ~a;
            wdata   = ~d;
        end else begin
            start = 1'b0;
        end
        got = -1;
        busy_ok = 1;
        strobe_ok = 1;
        for (int k = 0; k <= lat + 5; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy !== 1'b1) busy_ok = 0;
            if (done === 1'b1) begin
                got = k;
                break;
            end
            if ({mem_rd, mem_wr} !== (wr ? 2'b01 : 2'b10)) strobe_ok = 0;
        end
        chk({tag, "/latency"}, got, lat);
        chk({tag, "/busy_span"}, {31'h0, busy_ok}, 32'h1);
        chk({tag, "/strobes"}, {31'h0, strobe_ok}, 32'h1);
        chk({tag, "/error"}, {31'h0, error}, {31'h0, sm != 0});
        if (sm == 0 && !wr) ref_rdata = {ref_mem[a1], ref_mem[a]};
        if (wr && sm != 1) ref_mem[a] = d[7:0];
        if (wr && sm == 0) ref_mem[a1] = d[15:8];
        chk({tag, "/rdata"}, {16'h0, rdata}, {16'h0, ref_rdata});
        if (wr) begin
            chk({tag, "/mem_lo"}, {24'h0, tb_mem[a]}, {24'h0, ref_mem[a]});
            chk({tag, "/mem_hi"}, {24'h0, tb_mem[a1]}, {24'h0, ref_mem[a1]});
        end
        @(posedge clk);
        #1;
        if (poke) start = 1'b0;
        chk({tag, "/after_done"}, {29'h0, busy, done, error}, 32'h0);
        if (poke) begin
            @(posedge clk);
            #1;
            chk({tag, "/start_ignored"}, {31'h0, busy}, 32'h0);
        end
        chk({tag, "/pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          saw_done;
        bit          wr;
        int          w;
        int          sm;
        logic [15:0] a;

        for (int i = 0; i < 65536; i++) tb_mem[i] = 8'($urandom);
        tb_mem[16'h1000] = 8'h34;
        tb_mem[16'h1001] = 8'h12;
        ref_mem = tb_mem;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst/flags", {29'h0, busy, done, error}, 32'h0);
        chk("rst/strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
        chk("rst/rdata", {16'h0, rdata}, 32'h0);
        chk("rst/mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst/mem_wdata", {24'h0, mem_wdata}, 32'h0);
        chk("rst/state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("read0", 0, 16'h1000, 16'h0, 0, 0, 0, 0);
        chk("read0/value", {16'h0, rdata}, 32'h1234);
        run_op("timeout", 0, 16'h3000, 16'h0, 0, 1, 0, 0);
        chk("timeout/keep", {16'h0, rdata}, 32'h1234);
        run_op("write2", 1, 16'h2000, 16'hBEEF, 2, 0, 0, 0);
        chk("write2/lo", {24'h0, tb_mem[16'h2000]}, 32'hEF);
        chk("write2/hi", {24'h0, tb_mem[16'h2001]}, 32'hBE);
        run_op("wrap", 0, 16'hFFFF, 16'h0, 1, 0, 0, 0);
        run_op("poke", 0, 16'h1000, 16'h0, 0, 0, 0, 1);
        run_op("b2b_a", 0, 16'h4000, 16'h0, 0, 0, 0, 0);
        run_op("b2b_b", 1, 16'h4002, 16'hC0DE, 1, 0, 1, 0);
        run_op("tmo_b1", 1, 16'h5000, 16'hA55A, 1, 2, 0, 0);

        for (int n = 0; n < 14; n++) begin
            wr = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 3);
            sm = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            run_op("rand", wr, a, 16'($urandom), w, sm,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset while the second byte is still waiting
        launch(0, 16'h6000, 16'h0, 3, 0, 0);
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("rstmid/state", dbg_state, ST_BYTE1);
        chk("rstmid/rd_before", {31'h0, mem_rd}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid/strobes", {30'h0, mem_rd, mem_wr}, 32'h0);
        chk("rstmid/flags", {29'h0, busy, done, error}, 32'h0);
        ref_rdata = 16'h0;
        chk("rstmid/rdata", {16'h0, rdata}, 32'h0);
        saw_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1;
        end
        chk("rstmid/no_done", {31'h0, saw_done}, 32'h0);
        chk("rstmid/left", exp_q.size(), 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 0, 16'h1000, 16'h0, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
